serial_pattern_gen: RTL
=======================

# serial_pattern_gen

Serial bit-stream generator. It accepts a parallel word through a valid/ready handshake and shifts it out LSB-first, one bit per clock, on a single serial line. While doing so it tracks how many 0s and 1s it has sent. This is the source side of the serial sequence-detector path: its X output drives a detector's serial input, and its Qualified flag is the golden reference for the detector's "at least two 0s and two 1s seen" output.

## Interface
- WIDTH, 12: shift register width, i.e. maximum frame length in bits.
- MIN_ZEROS, 2: number of 0 bits required for qualification.
- MIN_ONES, 2: number of 1 bits required for qualification.
- LW (local), $clog2(WIDTH+1): width of the Length port.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Data  in  WIDTH  frame payload; bit 0 is transmitted first.
- Length  in  LW  number of bits to send. 0 means WIDTH; values above WIDTH clamp to WIDTH.
- DataValid  in  1  Data/Length are valid.
- DataReady  out  1  block can accept a frame.
- Abort  in  1  synchronous frame abort.
- X  out  1  serial data bit.
- XValid  out  1  X carries a frame bit this cycle.
- Busy  out  1  a frame is in progress (SHIFT or DONE).
- Done  out  1  one-cycle pulse when a frame completes normally.
- Qualified  out  1  the current or last frame has sent at least MIN_ZEROS 0s and at least MIN_ONES 1s.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state=IDLE; X=0, XValid=0, Busy=0, Done=0, Qualified=0. DataReady is 1, because it is decoded from IDLE.
- DataReady = (state==IDLE). Busy = (state != IDLE).
- IDLE:
  - A frame is accepted when DataValid && DataReady at a rising edge.
  - On accept: load the shift register with Data, load the bit counter with the effective length, clear both 0/1 counters, clear Qualified, go to SHIFT.
- SHIFT:
  - X = shreg[0] and XValid = 1, both registered.
  - Each cycle: shift right by one, decrement the remaining count, and increment the zero or one counter according to the bit just sent.
  - Both counters saturate at their MIN value and are $clog2(MIN+1) bits wide.
  - Qualified is set on the edge that ends the cycle in which the qualifying bit is on X. It stays set (sticky) until the next accept.
  - After the last bit, go to DONE.
- DONE: one cycle with Done=1, XValid=0, X=0. Then go to IDLE.
- Abort:
  - Sampled only in SHIFT.
  - Next state is IDLE; XValid and X drop to 0; Done is not pulsed; Qualified holds its current value.
  - Abort in IDLE or DONE is ignored.
- DataValid while not ready is ignored; the source must hold its frame until it sees DataReady.
- Resetn low mid-frame forces IDLE and all reset values immediately. The partial frame is lost.

## Timing
- Accept at edge k. Bit 0 is on X with XValid=1 during cycle k+1. Bit L-1 is on X during cycle k+L.
- Done=1 during cycle k+L+1. DataReady=1 from cycle k+L+2. The next accept can therefore happen no earlier than the edge ending cycle k+L+2.
- Frame period is L+2 cycles.
- Qualified behaves as a Moore output. If bit j completes the condition, Qualified=1 from cycle k+j+2. When the qualifying bit is the last bit, Qualified rises in the DONE cycle.
- All outputs are registered or state-decoded. There are no combinational paths from any input to any output.

## Test plan
- **Reset:** assert Resetn=0 mid-SHIFT of a 12-bit frame → X=0, XValid=0, Busy=0, Done=0, Qualified=0 immediately; DataReady=1.
- **Full frame:** Data=12'h6AE, Length=0 → X sequence 0 1 1 1 0 1 0 1 0 1 1 0 over 12 cycles. Qualified is 0 for the first 5 bits and rises while bit 5 is on X (cycle k+6). Done pulses in cycle k+13.
- **Never qualifies:** Data=12'hFFE, Length=12 → one 0 and eleven 1s sent; Qualified stays 0 through Done; Done pulses once.
- **Short frames:**
  - Length=4, Data=4'b0101 → X 1 0 1 0. Qualified rises in the DONE cycle.
  - Length=15 (above WIDTH) → clamped; exactly 12 bits sent.
- **Back-to-back:** DataValid held high with two frames (Data=12'h6AE, then Data=12'h000) → second accept exactly at the edge ending cycle k+L+2. No bit is lost or duplicated. Qualified clears on the second accept and stays 0, since the second frame contains only zeros.
- **Abort:** Abort=1 during bit 3 of 12'h6AE → IDLE next cycle, XValid=0, no Done pulse, Qualified=0. A new frame is accepted normally afterwards.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream source: accepts a parallel frame over valid/ready and shifts it out LSB-first,
// flagging (Qualified) once the frame has carried enough 0s and 1s.
module serial_pattern_gen #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned MIN_ZEROS = 2,
    parameter int unsigned MIN_ONES  = 2,
    localparam int unsigned LW       = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] Data,
    input  logic [LW-1:0]    Length,
    input  logic             DataValid,
    output logic             DataReady,
    input  logic             Abort,
    output logic             X,
    output logic             XValid,
    output logic             Busy,
    output logic             Done,
    output logic             Qualified
);

    localparam int unsigned ZW = (MIN_ZEROS > 0) ? $clog2(MIN_ZEROS + 1) : 1;
    localparam int unsigned OW = (MIN_ONES > 0) ? $clog2(MIN_ONES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LW-1:0]    remain;
    logic [ZW-1:0]    zcnt;
    logic [OW-1:0]    ocnt;
    logic             x_q;
    logic             qual_q;

    logic [LW-1:0]    eff_len;
    logic [ZW-1:0]    zcnt_nxt;
    logic [OW-1:0]    ocnt_nxt;
    logic             qual_hit;

    // Length 0 and anything above WIDTH both mean a full-width frame
    always_comb begin
        eff_len = Length;
        if (Length == LW'(0) || Length > LW'(WIDTH)) begin
            eff_len = LW'(WIDTH);
        end
    end

    // Saturating tallies including the bit currently on X
    always_comb begin
        zcnt_nxt = zcnt;
        ocnt_nxt = ocnt;
        if (!x_q && zcnt != ZW'(MIN_ZEROS)) begin
            zcnt_nxt = zcnt + ZW'(1);
        end
        if (x_q && ocnt != OW'(MIN_ONES)) begin
            ocnt_nxt = ocnt + OW'(1);
        end
        qual_hit = (zcnt_nxt == ZW'(MIN_ZEROS)) && (ocnt_nxt == OW'(MIN_ONES));
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            shreg  <= '0;
            remain <= '0;
            zcnt   <= '0;
            ocnt   <= '0;
            x_q    <= 1'b0;
            qual_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (DataValid) begin
                        x_q    <= Data[0];
                        shreg  <= Data >> 1;
                        remain <= eff_len;
                        zcnt   <= '0;
                        ocnt   <= '0;
                        qual_q <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (Abort) begin
                        // Partial frame dropped; Qualified keeps what it has seen so far
                        x_q   <= 1'b0;
                        state <= IDLE;
                    end else begin
                        zcnt   <= zcnt_nxt;
                        ocnt   <= ocnt_nxt;
                        qual_q <= qual_q | qual_hit;
                        remain <= remain - LW'(1);
                        if (remain == LW'(1)) begin
                            x_q   <= 1'b0;
                            state <= DONE;
                        end else begin
                            x_q   <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign DataReady = (state == IDLE);
    assign Busy      = (state != IDLE);
    assign XValid    = (state == SHIFT);
    assign Done      = (state == DONE);
    assign X         = x_q;
    assign Qualified = qual_q;

endmodule
